// File: rtl/ball_sprite_render.sv
// rtl/ball_sprite_render.sv - ball sprite overlay stage with bitmap RAM interface and CPU register decode
module ball_sprite_render #(
  parameter int CD         = 12,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2,
  parameter int SIZE       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [CD-1:0]         si_rgb,
  output logic [CD-1:0]         so_rgb,
  input  logic                  wr_en,
  input  logic [8:0]            wr_addr,
  input  logic [31:0]           wr_data,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_din
);

  // shadow and active sprite origin
  logic [10:0]   sbx, sby, abx, aby;
  logic          enable;
  logic [CD-1:0] pal1, pal2, pal3;

  // stage 1 / stage 2 pipeline registers
  logic          hit1, hit2;
  logic [CD-1:0] rgb1, rgb2;

  // position compares widened by one bit so the sprite end never wraps
  logic [11:0]   x_end, y_end;
  logic          in_x, in_y;
  logic [3:0]    dx, dy;
  logic          frame_start;
  logic          reg_wr;

  // upper write-data bits are not used by any register
  logic          unused_wr_data;
  assign unused_wr_data = &{1'b0, wr_data[31:CD]};

  assign x_end       = {1'b0, abx} + 12'(SIZE);
  assign y_end       = {1'b0, aby} + 12'(SIZE);
  assign in_x        = ({1'b0, x} >= {1'b0, abx}) && ({1'b0, x} < x_end);
  assign in_y        = ({1'b0, y} >= {1'b0, aby}) && ({1'b0, y} < y_end);
  assign dx          = x[3:0] - abx[3:0];
  assign dy          = y[3:0] - aby[3:0];
  assign frame_start = (x == 11'd0) && (y == 11'd0);
  assign reg_wr      = wr_en && !wr_addr[8];

  // register file: shadow position, ctrl, palette; active position commits at frame start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbx    <= '0;
      sby    <= '0;
      abx    <= '0;
      aby    <= '0;
      enable <= 1'b0;
      pal1   <= CD'(12'hFFF);
      pal2   <= CD'(12'h000);
      pal3   <= CD'(12'h888);
    end else begin
      // commit reads the pre-write shadow, so a same-cycle write lands next frame
      if (frame_start) begin
        abx <= sbx;
        aby <= sby;
      end
      if (reg_wr) begin
        case (wr_addr[2:0])
          3'd0:    sbx    <= wr_data[10:0];
          3'd1:    sby    <= wr_data[10:0];
          3'd2:    enable <= wr_data[0];
          3'd3:    pal1   <= wr_data[CD-1:0];
          3'd4:    pal2   <= wr_data[CD-1:0];
          3'd5:    pal3   <= wr_data[CD-1:0];
          default: ;
        endcase
      end
    end
  end

  // bitmap RAM write port: registered copy of CPU bitmap writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_we     <= 1'b0;
      ram_addr_w <= '0;
      ram_din    <= '0;
    end else begin
      ram_we <= wr_en && wr_addr[8];
      if (wr_en && wr_addr[8]) begin
        ram_addr_w <= ADDR_WIDTH'(wr_addr[7:0]);
        ram_din    <= wr_data[DATA_WIDTH-1:0];
      end
    end
  end

  // stages 1 and 2: hit test, read address (held on miss), pixel delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit1       <= 1'b0;
      hit2       <= 1'b0;
      rgb1       <= '0;
      rgb2       <= '0;
      ram_addr_r <= '0;
    end else begin
      hit1 <= enable && in_x && in_y;
      rgb1 <= si_rgb;
      if (enable && in_x && in_y) begin
        ram_addr_r <= ADDR_WIDTH'({dy, dx});
      end
      hit2 <= hit1;
      rgb2 <= rgb1;
    end
  end

  // stage 3: palette lookup with index 0 transparent
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      so_rgb <= '0;
    end else if (hit2 && (ram_dout != '0)) begin
      case (ram_dout)
        2'd1:    so_rgb <= pal1;
        2'd2:    so_rgb <= pal2;
        default: so_rgb <= pal3;
      endcase
    end else begin
      so_rgb <= rgb2;
    end
  end

endmodule

// File: tb/tb_ball_sprite_render.sv
// tb/tb_ball_sprite_render.sv - randomized self-checking bench for ball_sprite_render
module tb_ball_sprite_render;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic [11:0] si_rgb, so_rgb;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  ram_addr_r, ram_addr_w;
  logic [1:0]  ram_dout, ram_din;
  logic        ram_we;

  always #5 clk = ~clk;

  ball_sprite_render dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .si_rgb     (si_rgb),
    .so_rgb     (so_rgb),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ram_addr_r (ram_addr_r),
    .ram_dout   (ram_dout),
    .ram_we     (ram_we),
    .ram_addr_w (ram_addr_w),
    .ram_din    (ram_din)
  );

  // external bitmap RAM with one-cycle synchronous read
  logic [1:0] mem [256];
  always @(posedge clk) begin
    ram_dout <= mem[ram_addr_r];
    if (ram_we) mem[ram_addr_w] <= ram_din;
  end

  // reference model state
  int          m_sbx, m_sby, m_abx, m_aby;
  bit          m_en;
  logic [11:0] m_pal [4];
  logic [1:0]  ref_bmp [256];
  logic [11:0] hist [3];
  logic [7:0]  m_addr;
  bit          m_we;
  logic [7:0]  m_aw;
  logic [1:0]  m_din;
  bit          rst_drive;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sbx = 0; m_sby = 0; m_abx = 0; m_aby = 0; m_en = 0;
    m_pal[0] = 12'h000; m_pal[1] = 12'hFFF; m_pal[2] = 12'h000; m_pal[3] = 12'h888;
    for (int i = 0; i < 3; i++) hist[i] = 12'h000;
    m_addr = 8'h00; m_we = 0; m_aw = 8'h00; m_din = 2'b00;
  endtask

  // one clock: check outputs from earlier cycles, present new inputs, advance the model
  task automatic step(input int px, input int py, input logic [11:0] prgb,
                      input bit we, input logic [8:0] wa, input logic [31:0] wd);
    bit         hit;
    logic [1:0] idx;
    logic [11:0] e;
    @(negedge clk);
    check_eq("so_rgb", so_rgb, hist[2]);
    check_eq("ram_addr_r", ram_addr_r, m_addr);
    check_eq("ram_we", ram_we, m_we);
    if (m_we) begin
      check_eq("ram_addr_w", ram_addr_w, m_aw);
      check_eq("ram_din", ram_din, m_din);
    end
    reset_n = rst_drive;
    x       = px[10:0];
    y       = py[10:0];
    si_rgb  = prgb;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    if (!rst_drive) begin
      model_reset();
    end else begin
      hit = m_en && px >= m_abx && px < m_abx + 16 && py >= m_aby && py < m_aby + 16;
      idx = ref_bmp[((py - m_aby) & 15) * 16 + ((px - m_abx) & 15)];
      e   = (hit && idx != 2'd0) ? m_pal[idx] : prgb;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = e;
      if (hit) m_addr = 8'(((py - m_aby) & 15) * 16 + ((px - m_abx) & 15));
      m_we = we && wa[8];
      if (m_we) begin
        m_aw = wa[7:0];
        m_din = wd[1:0];
        ref_bmp[wa[7:0]] = wd[1:0];
      end
      if (px == 0 && py == 0) begin
        m_abx = m_sbx;
        m_aby = m_sby;
      end
      if (we && !wa[8]) begin
        case (wa[2:0])
          3'd0: m_sbx = int'(wd[10:0]);
          3'd1: m_sby = int'(wd[10:0]);
          3'd2: m_en  = wd[0];
          3'd3: m_pal[1] = wd[11:0];
          3'd4: m_pal[2] = wd[11:0];
          3'd5: m_pal[3] = wd[11:0];
          default: ;
        endcase
      end
    end
  endtask

  // off-sprite position used while writing registers and the bitmap
  task automatic idle(input int n, input logic [11:0] rgb);
    for (int i = 0; i < n; i++) step(1000, 1000, rgb, 0, 9'h000, 32'h0);
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d);
    step(1000, 1000, 12'($urandom), 1, a, d);
  endtask

  // raster window around the sprite, skipping (0,0) so commits stay explicit
  task automatic scan(input int bx, input int by);
    for (int yy = by - 2; yy < by + 18; yy++) begin
      for (int xx = bx - 2; xx < bx + 18; xx++) begin
        if (xx >= 0 && xx < 2048 && yy >= 0 && yy < 2048 && !(xx == 0 && yy == 0))
          step(xx, yy, 12'($urandom), 0, 9'h000, 32'h0);
      end
    end
  endtask

  task automatic do_reset_async();
    @(posedge clk);
    #2;
    reset_n   = 1'b0;
    rst_drive = 1'b0;
    #1;
    check_eq("async_rst_so_rgb", so_rgb, 32'h0);
    check_eq("async_rst_ram_addr_r", ram_addr_r, 32'h0);
    check_eq("async_rst_ram_we", ram_we, 32'h0);
    model_reset();
  endtask

  initial begin
    reset_n = 1'b0; rst_drive = 1'b0;
    x = 11'd1000; y = 11'd1000; si_rgb = 12'h123;
    wr_en = 1'b0; wr_addr = 9'h000; wr_data = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 2'b00;
      ref_bmp[i] = 2'b00;
    end
    model_reset();

    // reset hold, then pass-through of a constant pixel
    for (int i = 0; i < 8; i++) step(1000, 1000, 12'h123, 0, 9'h000, 32'h0);
    rst_drive = 1'b1;
    idle(6, 12'h123);

    // fill the bitmap through the CPU port
    for (int i = 0; i < 256; i++) wr({1'b1, 8'(i)}, $urandom);
    wr(9'h1A5, 32'h3);
    wr(9'h100, 32'h2);
    wr(9'h1FF, 32'h1);
    idle(3, 12'h456);

    // ball at (100,50), green palette entry 2
    wr(9'h000, 32'd100);
    wr(9'h001, 32'd50);
    wr(9'h002, 32'd1);
    wr(9'h004, 32'h0F0);
    idle(3, 12'h789);
    step(0, 0, 12'h321, 0, 9'h000, 32'h0);
    step(100, 50, 12'hABC, 0, 9'h000, 32'h0);
    step(115, 65, 12'hABC, 0, 9'h000, 32'h0);
    step(116, 65, 12'h5A5, 0, 9'h000, 32'h0);
    idle(3, 12'h246);
    scan(100, 50);

    // mid-frame shadow write, commit with a same-cycle write deferred a frame
    step(300, 200, 12'h111, 1, 9'h000, 32'd200);
    scan(100, 50);
    step(0, 0, 12'h222, 1, 9'h000, 32'd300);
    scan(200, 50);
    scan(100, 50);
    step(0, 0, 12'h333, 0, 9'h000, 32'h0);
    scan(300, 50);

    // sprite at the top of the 11-bit range must not wrap to column 0
    wr(9'h000, 32'd2040);
    wr(9'h001, 32'd10);
    wr(9'h006, 32'h0);
    wr(9'h007, 32'h0);
    idle(3, 12'h000);
    step(0, 0, 12'h444, 0, 9'h000, 32'h0);
    scan(2040, 10);
    scan(0, 10);

    // randomized configurations including partial off-screen positions
    for (int r = 0; r < 8; r++) begin
      wr(9'h000, (r % 3 == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom_range(0, 639)));
      wr(9'h001, (r % 3 == 1) ? 32'($urandom_range(0, 8)) : 32'($urandom_range(0, 479)));
      wr(9'h002, ($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
      wr(9'h003, $urandom);
      wr(9'h004, $urandom);
      wr(9'h005, $urandom);
      for (int k = 0; k < 20; k++) wr({1'b1, 8'($urandom)}, $urandom);
      idle(3, 12'($urandom));
      step(0, 0, 12'($urandom), 0, 9'h000, 32'h0);
      scan(m_abx, m_aby);
      if (r == 4) begin
        do_reset_async();
        for (int i = 0; i < 4; i++) step(1000, 1000, 12'($urandom), 0, 9'h000, 32'h0);
        rst_drive = 1'b1;
        idle(5, 12'($urandom));
        step(0, 0, 12'($urandom), 0, 9'h000, 32'h0);
        scan(0, 0);
      end
    end

    idle(4, 12'h000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
